// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline RAW-hazard and branch-flush controller with perf counters
module hazard_ctrl #(
  parameter int unsigned FWD_EN = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [3:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             exe_branch_taken,
  output logic             freeze,
  output logic             flush,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Shadow copy of what the ID/EX and EX/MEM registers hold
  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       wb_en;
    logic       mem_r_en;
  } slot_t;

  slot_t exe_slot;
  slot_t mem_slot;

  logic hit_exe;
  logic hit_mem;
  logic hazard;

  // Register-match of the ID sources against each in-flight producer
  always_comb begin
    hit_exe = exe_slot.valid & exe_slot.wb_en &
              ((id_use_src1 & (id_src1 == exe_slot.dest)) |
               (id_use_src2 & (id_src2 == exe_slot.dest)));
    hit_mem = mem_slot.valid & mem_slot.wb_en &
              ((id_use_src1 & (id_src1 == mem_slot.dest)) |
               (id_use_src2 & (id_src2 == mem_slot.dest)));
    if (FWD_EN != 0) begin
      // Forwarding covers everything except a load result still in EXE
      hazard = id_valid & hit_exe & exe_slot.mem_r_en;
    end else begin
      hazard = id_valid & (hit_exe | hit_mem);
    end
  end

  // Pipeline control; a taken branch wins because the ID instruction is wrong-path
  always_comb begin
    freeze   = 1'b0;
    flush    = 1'b0;
    if_flush = 1'b0;
    if (RST) begin
      if (exe_branch_taken) begin
        flush    = 1'b1;
        if_flush = 1'b1;
      end else if (hazard) begin
        freeze = 1'b1;
        flush  = 1'b1;
      end
    end
  end

  // Slots advance every edge; a bubble enters EXE whenever ID/EX is cleared
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exe_slot <= '0;
      mem_slot <= '0;
    end else begin
      mem_slot <= exe_slot;
      if (flush || !id_valid) begin
        exe_slot <= '0;
      end else begin
        exe_slot <= '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};
      end
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (freeze && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
      if (exe_branch_taken && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       CLK;
  logic       RST;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_use_src1;
  logic       id_use_src2;
  logic [3:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       exe_branch_taken;

  logic       freeze0, flush0, if_flush0;
  logic [3:0] stall_count0, flush_count0;
  logic       freeze1, flush1, if_flush1;
  logic [15:0] stall_count1, flush_count1;

  int tests;
  int fails;

  hazard_ctrl #(.FWD_EN(0), .CNT_W(4)) u0 (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .exe_branch_taken(exe_branch_taken),
    .freeze(freeze0), .flush(flush0), .if_flush(if_flush0),
    .stall_count(stall_count0), .flush_count(flush_count0)
  );

  hazard_ctrl #(.FWD_EN(1), .CNT_W(16)) u1 (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .exe_branch_taken(exe_branch_taken),
    .freeze(freeze1), .flush(flush1), .if_flush(if_flush1),
    .stall_count(stall_count1), .flush_count(flush_count1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic v, input logic [3:0] s1, input logic u1s, input logic [3:0] s2,
                       input logic u2s, input logic [3:0] d, input logic wb, input logic mr);
    id_valid    = v;
    id_src1     = s1;
    id_use_src1 = u1s;
    id_src2     = s2;
    id_use_src2 = u2s;
    id_dest     = d;
    id_wb_en    = wb;
    id_mem_r_en = mr;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    exe_branch_taken = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    RST = 1'b0;
    step();
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd1, 1'b1, 4'd5, 1'b0, 4'd6, 1'b1, 1'b0);
    tests++;
    if (freeze0 !== 1'b1 || flush0 !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_stall: freeze=%b flush=%b expected 1 1", freeze0, flush0);
    end
    RST = 1'b0;
    #1;
    tests++;
    if (freeze0 !== 1'b0 || flush0 !== 1'b0 || if_flush0 !== 1'b0) begin
      fails++;
      $display("FAIL rst_async_outputs: freeze=%b flush=%b if_flush=%b expected 0 0 0",
               freeze0, flush0, if_flush0);
    end
    tests++;
    if (stall_count0 !== 4'd0 || flush_count0 !== 4'd0) begin
      fails++;
      $display("FAIL rst_counters: stall=%0d flush=%0d expected 0 0", stall_count0, flush_count0);
    end
    step();
    RST = 1'b1;
    #1;
    tests++;
    if (freeze0 !== 1'b0 || flush0 !== 1'b0 || stall_count0 !== 4'd0) begin
      fails++;
      $display("FAIL rst_release_no_stall: freeze=%b flush=%b stall=%0d expected 0 0 0",
               freeze0, flush0, stall_count0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd1, 1'b1, 1'b0);
    tests++;
    if (freeze0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_producer: freeze=%b expected 0", freeze0);
    end
    step();
    drive(1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0);
    tests++;
    if (freeze0 !== 1'b1 || flush0 !== 1'b1 || if_flush0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_cycle1: freeze=%b flush=%b if_flush=%b expected 1 1 0", freeze0, flush0, if_flush0);
    end
    step();
    tests++;
    if (freeze0 !== 1'b1 || flush0 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_cycle2: freeze=%b flush=%b expected 1 1", freeze0, flush0);
    end
    step();
    tests++;
    if (freeze0 !== 1'b0 || flush0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_cycle3: freeze=%b flush=%b expected 0 0", freeze0, flush0);
    end
    tests++;
    if (stall_count0 !== 4'd2) begin
      fails++;
      $display("FAIL b2b_stall_count: got %0d expected 2", stall_count0);
    end
  endtask

  task automatic test_one_gap();
    do_reset();
    drive(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd7, 1'b1, 4'd8, 1'b1, 4'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd9, 1'b1, 4'd1, 1'b1, 4'd6, 1'b1, 1'b0);
    tests++;
    if (freeze0 !== 1'b1) begin
      fails++;
      $display("FAIL gap_mem_hit: freeze=%b expected 1", freeze0);
    end
    step();
    tests++;
    if (freeze0 !== 1'b0 || stall_count0 !== 4'd1) begin
      fails++;
      $display("FAIL gap_release: freeze=%b stall=%0d expected 0 1", freeze0, stall_count0);
    end
  endtask

  task automatic test_fwd_load_use();
    do_reset();
    drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
    step();
    drive(1'b1, 4'd7, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);
    tests++;
    if (freeze1 !== 1'b1 || flush1 !== 1'b1) begin
      fails++;
      $display("FAIL fwd_load_use: freeze=%b flush=%b expected 1 1", freeze1, flush1);
    end
    step();
    tests++;
    if (freeze1 !== 1'b0 || stall_count1 !== 16'd1) begin
      fails++;
      $display("FAIL fwd_load_release: freeze=%b stall=%0d expected 0 1", freeze1, stall_count1);
    end
    do_reset();
    drive(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd7, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);
    tests++;
    if (freeze1 !== 1'b0 || flush1 !== 1'b0) begin
      fails++;
      $display("FAIL fwd_alu_no_stall: freeze=%b flush=%b expected 0 0", freeze1, flush1);
    end
    step();
    tests++;
    if (stall_count1 !== 16'd0) begin
      fails++;
      $display("FAIL fwd_alu_count: got %0d expected 0", stall_count1);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd14, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
    exe_branch_taken = 1'b1;
    #1;
    tests++;
    if (if_flush0 !== 1'b1 || flush0 !== 1'b1 || freeze0 !== 1'b0) begin
      fails++;
      $display("FAIL branch_priority: if_flush=%b flush=%b freeze=%b expected 1 1 0",
               if_flush0, flush0, freeze0);
    end
    step();
    exe_branch_taken = 1'b0;
    drive(1'b1, 4'd5, 1'b1, 4'd3, 1'b1, 4'd8, 1'b1, 1'b0);
    tests++;
    if (flush_count0 !== 4'd1) begin
      fails++;
      $display("FAIL branch_flush_count: got %0d expected 1", flush_count0);
    end
    tests++;
    if (freeze0 !== 1'b0 || flush0 !== 1'b0 || if_flush0 !== 1'b0) begin
      fails++;
      $display("FAIL branch_killed_no_stall: freeze=%b flush=%b if_flush=%b expected 0 0 0",
               freeze0, flush0, if_flush0);
    end
  endtask

  task automatic test_false_match();
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd8, 1'b1, 4'd3, 1'b0, 4'd9, 1'b1, 1'b0);
    tests++;
    if (freeze0 !== 1'b0) begin
      fails++;
      $display("FAIL false_use_src2: freeze=%b expected 0", freeze0);
    end
    drive(1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 4'd9, 1'b1, 1'b0);
    tests++;
    if (freeze0 !== 1'b0 || flush0 !== 1'b0) begin
      fails++;
      $display("FAIL false_id_invalid: freeze=%b flush=%b expected 0 0", freeze0, flush0);
    end
    do_reset();
    drive(1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 4'd3, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    tests++;
    if (freeze0 !== 1'b0) begin
      fails++;
      $display("FAIL false_no_wb: freeze=%b expected 0", freeze0);
    end
    do_reset();
    drive(1'b1, 4'd9, 1'b1, 4'd9, 1'b1, 4'd9, 1'b1, 1'b1);
    tests++;
    if (freeze0 !== 1'b0 || freeze1 !== 1'b0) begin
      fails++;
      $display("FAIL false_self_dest: freeze0=%b freeze1=%b expected 0 0", freeze0, freeze1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
      step();
      drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
      step();
      step();
      step();
      if (i == 6) begin
        tests++;
        if (stall_count0 !== 4'd14) begin
          fails++;
          $display("FAIL sat_mid: got %0d expected 14", stall_count0);
        end
      end
    end
    tests++;
    if (stall_count0 !== 4'd15) begin
      fails++;
      $display("FAIL sat_hold: got %0d expected 15", stall_count0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST = 1'b0;
    exe_branch_taken = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tests++;
    if (freeze0 !== 1'b0 || flush0 !== 1'b0 || if_flush0 !== 1'b0 || stall_count1 !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: freeze=%b flush=%b if_flush=%b stall1=%0d expected 0 0 0 0",
               freeze0, flush0, if_flush0, stall_count1);
    end
    test_reset_mid_stall();
    test_back_to_back();
    test_one_gap();
    test_fwd_load_use();
    test_branch();
    test_false_match();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
